// File: rtl/spi_flash_pkg.sv
// rtl/spi_flash_pkg.sv - shared types and constants for the SPI flash slave
package spi_flash_pkg;
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_DATA,
    ST_IGNORE
  } state_t;

  localparam logic [7:0] CMD_READ = 8'h03;
  localparam int         ADDR_W   = 24;
  localparam int         DATA_W   = 32;
endpackage

// File: rtl/spi_flash_sync.sv
// rtl/spi_flash_sync.sv - 2-flop synchronizer with optional rise/fall detect
module spi_flash_sync #(
  parameter bit EDGE_DET = 1'b1
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q,
  output logic o_rise,
  output logic o_fall
);
  logic [1:0] r_sync;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_sync <= 2'b00;
    else       r_sync <= {r_sync[0], i_d};
  end

  assign o_q = r_sync[1];

  generate
    if (EDGE_DET) begin : g_edge
      logic r_prev;
      always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_prev <= 1'b0;
        else       r_prev <= r_sync[1];
      end
      assign o_rise = r_sync[1] & ~r_prev;
      assign o_fall = ~r_sync[1] & r_prev;
    end else begin : g_no_edge
      assign o_rise = 1'b0;
      assign o_fall = 1'b0;
    end
  endgenerate
endmodule

// File: rtl/spi_flash.sv
// rtl/spi_flash.sv - SPI NOR-flash READ (0x03) slave backed by a 32-bit BRAM port
module spi_flash
  import spi_flash_pkg::*;
(
  input  logic              ap_clk,
  input  logic              ap_rst,
  input  logic              csb,
  input  logic              spiclk,
  input  logic              io0,
  output logic              io1,
  output logic [DATA_W-1:0] romcode_Addr_A,
  output logic              romcode_EN_A,
  output logic [3:0]        romcode_WEN_A,
  output logic [DATA_W-1:0] romcode_Din_A,
  input  logic [DATA_W-1:0] romcode_Dout_A,
  output logic              romcode_Clk_A,
  output logic              romcode_Rst_A
);
  state_t              r_state, w_state_nxt;
  logic                w_csb, w_mosi, w_sclk_unused, w_sclk_rise, w_sclk_fall;
  logic                w_csb_rise_unused, w_csb_fall_unused;
  logic                w_mosi_rise_unused, w_mosi_fall_unused;
  logic                r_csb_prev, w_csb_fall;
  logic [4:0]          r_bit_cnt;
  logic [ADDR_W-2:0]   r_shift;
  logic [ADDR_W-1:0]   r_addr, w_addr_nxt;
  logic                w_last_bit, w_fetch;
  logic                r_en, r_en_d, r_io1;
  logic [7:0]          r_byte;
  logic [DATA_W-1:0]   r_addr_a;

  spi_flash_sync #(.EDGE_DET(1'b1)) u_sync_sclk (
    .i_clk(ap_clk), .i_rst(ap_rst), .i_d(spiclk),
    .o_q(w_sclk_unused), .o_rise(w_sclk_rise), .o_fall(w_sclk_fall)
  );
  spi_flash_sync #(.EDGE_DET(1'b0)) u_sync_csb (
    .i_clk(ap_clk), .i_rst(ap_rst), .i_d(csb),
    .o_q(w_csb), .o_rise(w_csb_rise_unused), .o_fall(w_csb_fall_unused)
  );
  spi_flash_sync #(.EDGE_DET(1'b0)) u_sync_mosi (
    .i_clk(ap_clk), .i_rst(ap_rst), .i_d(io0),
    .o_q(w_mosi), .o_rise(w_mosi_rise_unused), .o_fall(w_mosi_fall_unused)
  );

  // csb sync resets low, so a csb held low across reset never looks like a new frame
  assign w_csb_fall = r_csb_prev & ~w_csb;

  always_comb begin
    w_last_bit = 1'b0;
    case (r_state)
      ST_CMD:  w_last_bit = (r_bit_cnt == 5'd7);
      ST_ADDR: w_last_bit = (r_bit_cnt == 5'd23);
      ST_DATA: w_last_bit = (r_bit_cnt == 5'd7);
      default: ;
    endcase
  end

  assign w_fetch    = ~w_csb & w_sclk_rise & w_last_bit &
                      ((r_state == ST_ADDR) | (r_state == ST_DATA));
  assign w_addr_nxt = (r_state == ST_DATA) ? r_addr + 1'b1 : {r_shift, w_mosi};

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (w_csb) begin
      w_state_nxt = ST_IDLE;
    end else if (r_state == ST_IDLE) begin
      if (w_csb_fall) w_state_nxt = ST_CMD;
    end else if (w_sclk_rise && w_last_bit) begin
      case (r_state)
        ST_CMD:  w_state_nxt = ({r_shift[6:0], w_mosi} == CMD_READ) ? ST_ADDR : ST_IGNORE;
        ST_ADDR: w_state_nxt = ST_DATA;
        default: ;
      endcase
    end
  end

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      r_csb_prev <= 1'b0;
      r_en       <= 1'b0;
      r_en_d     <= 1'b0;
      r_bit_cnt  <= '0;
      r_shift    <= '0;
      r_addr     <= '0;
      r_addr_a   <= '0;
      r_byte     <= '0;
      r_io1      <= 1'b0;
    end else begin
      r_csb_prev <= w_csb;
      r_en       <= w_fetch;
      r_en_d     <= r_en;
      if (w_csb || r_state == ST_IDLE) begin
        r_bit_cnt <= '0;
        r_shift   <= '0;
      end else if (w_sclk_rise) begin
        r_shift   <= {r_shift[ADDR_W-3:0], w_mosi};
        r_bit_cnt <= w_last_bit ? 5'd0 : r_bit_cnt + 5'd1;
      end
      if (w_fetch) begin
        r_addr   <= w_addr_nxt;
        r_addr_a <= {{(DATA_W-ADDR_W){1'b0}}, w_addr_nxt[ADDR_W-1:2], 2'b00};
      end
      // Results of a fetch still in flight when csb rises are dropped here
      if (r_en_d && r_state == ST_DATA)
        r_byte <= romcode_Dout_A[{r_addr[1:0], 3'b000} +: 8];
      if (w_csb || r_state != ST_DATA) r_io1 <= 1'b0;
      else if (w_sclk_fall)            r_io1 <= r_byte[3'd7 - r_bit_cnt[2:0]];
    end
  end

  assign io1            = r_io1;
  assign romcode_Addr_A = r_addr_a;
  assign romcode_EN_A   = r_en;
  assign romcode_WEN_A  = 4'b0000;
  assign romcode_Din_A  = '0;
  assign romcode_Clk_A  = ap_clk;
  assign romcode_Rst_A  = ap_rst;
endmodule

// File: tb/tb_spi_flash.sv
// tb/tb_spi_flash.sv - randomized self-checking bench for spi_flash
module tb_spi_flash;
  logic        ap_clk = 1'b0;
  logic        ap_rst = 1'b1;
  logic        csb    = 1'b1;
  logic        spiclk = 1'b0;
  logic        io0    = 1'b0;
  logic        io1;
  logic [31:0] romcode_Addr_A;
  logic        romcode_EN_A;
  logic [3:0]  romcode_WEN_A;
  logic [31:0] romcode_Din_A;
  logic [31:0] romcode_Dout_A = '0;
  logic        romcode_Clk_A, romcode_Rst_A;

  spi_flash dut (
    .ap_clk(ap_clk), .ap_rst(ap_rst), .csb(csb), .spiclk(spiclk), .io0(io0), .io1(io1),
    .romcode_Addr_A(romcode_Addr_A), .romcode_EN_A(romcode_EN_A),
    .romcode_WEN_A(romcode_WEN_A), .romcode_Din_A(romcode_Din_A),
    .romcode_Dout_A(romcode_Dout_A), .romcode_Clk_A(romcode_Clk_A),
    .romcode_Rst_A(romcode_Rst_A)
  );

  always #5 ap_clk = ~ap_clk;

  logic [31:0] mem [64];
  always @(posedge ap_clk) if (romcode_EN_A) romcode_Dout_A <= mem[romcode_Addr_A[7:2]];

  int          n_tests = 0, n_fail = 0, en_count = 0;
  bit          data_phase = 1'b0;
  logic [31:0] exp_fetch[$];
  logic [7:0]  rd[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: byte a lives in little-endian lane a[1:0] of word a>>2
  function automatic logic [7:0] byte_at(input logic [23:0] a);
    logic [31:0] w;
    w = mem[a[7:2]];
    return w[8*a[1:0] +: 8];
  endfunction

  always @(negedge ap_clk) begin
    if (!data_phase) check("io1_quiet", 32'(io1), 32'h0);
    if (romcode_EN_A) begin
      en_count++;
      check("wen_zero", 32'(romcode_WEN_A), 32'h0);
      check("din_zero", romcode_Din_A, 32'h0);
      if (exp_fetch.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL fetch_unexpected: EN_A with Addr_A=0x%0h, none expected", romcode_Addr_A);
      end else begin
        check("fetch_addr", romcode_Addr_A, exp_fetch.pop_front());
      end
    end
  end

  task automatic spi_bit(input logic b, input bit push, input logic [23:0] fa, output logic miso);
    io0 = b;
    repeat ($urandom_range(7, 9)) @(posedge ap_clk);
    @(negedge ap_clk);
    miso   = io1;
    spiclk = 1'b1;
    if (push) exp_fetch.push_back({8'h00, fa[23:2], 2'b00});
    repeat ($urandom_range(7, 9)) @(posedge ap_clk);
    #1 spiclk = 1'b0;
  endtask

  task automatic csb_low();
    @(negedge ap_clk);
    csb = 1'b0;
    repeat (4) @(posedge ap_clk);
  endtask

  task automatic csb_high();
    repeat (4) @(posedge ap_clk);
    #1 csb = 1'b1;
    repeat (5) @(posedge ap_clk);
    #1 data_phase = 1'b0;
    repeat (3) @(posedge ap_clk);
    check("fetch_drained", 32'(exp_fetch.size()), 32'h0);
  endtask

  task automatic send_cmd_addr(input logic [7:0] cmd, input logic [23:0] a, input int nabits,
                               input bit fetch_ok);
    logic m;
    for (int i = 7; i >= 0; i--) spi_bit(cmd[i], 1'b0, 24'h0, m);
    for (int i = 23; i >= 24 - nabits; i--)
      spi_bit(a[i], fetch_ok && (i == 0) && (cmd == 8'h03), a, m);
  endtask

  task automatic read_bytes(input logic [23:0] a, input int n);
    logic [7:0]  got;
    logic [23:0] cur;
    logic        m;
    data_phase = 1'b1;
    for (int b = 0; b < n; b++) begin
      cur = a + 24'(b);
      for (int k = 7; k >= 0; k--) begin
        spi_bit(1'b0, k == 0, cur + 24'd1, m);
        got[k] = m;
      end
      check("read_byte", 32'(got), 32'(byte_at(cur)));
      rd.push_back(got);
    end
  endtask

  task automatic do_read(input logic [23:0] a, input int n);
    int e0;
    rd.delete();
    e0 = en_count;
    csb_low();
    send_cmd_addr(8'h03, a, 24, 1'b1);
    read_bytes(a, n);
    csb_high();
    check("en_pulses", 32'(en_count - e0), 32'(n + 1));
  endtask

  initial begin
    int   e0;
    logic m;
    mem[0] = 32'h4433_2211;
    mem[1] = 32'h8877_6655;
    for (int i = 2; i < 64; i++) mem[i] = $urandom;

    repeat (3) @(posedge ap_clk);
    @(negedge ap_clk);
    check("rst_io1", 32'(io1), 32'h0);
    check("rst_en", 32'(romcode_EN_A), 32'h0);
    check("rst_wen", 32'(romcode_WEN_A), 32'h0);
    check("rst_addr", romcode_Addr_A, 32'h0);
    check("rst_rst_a", 32'(romcode_Rst_A), 32'h1);
    check("clk_a_low", 32'(romcode_Clk_A), 32'(ap_clk));
    @(posedge ap_clk); #1;
    check("clk_a_high", 32'(romcode_Clk_A), 32'(ap_clk));
    #1 ap_rst = 1'b0;
    repeat (5) @(posedge ap_clk);

    do_read(24'h000000, 4);
    check("t1_b0", 32'(rd[0]), 32'h11);
    check("t1_b1", 32'(rd[1]), 32'h22);
    check("t1_b2", 32'(rd[2]), 32'h33);
    check("t1_b3", 32'(rd[3]), 32'h44);

    do_read(24'h000002, 4);
    check("t2_b0", 32'(rd[0]), 32'h33);
    check("t2_b1", 32'(rd[1]), 32'h44);
    check("t2_b2", 32'(rd[2]), 32'h55);
    check("t2_b3", 32'(rd[3]), 32'h66);

    e0 = en_count;
    csb_low();
    send_cmd_addr(8'hAB, 24'h0, 0, 1'b0);
    for (int i = 0; i < 32; i++) spi_bit(1'($urandom), 1'b0, 24'h0, m);
    csb_high();
    check("ignore_no_en", 32'(en_count - e0), 32'h0);
    do_read(24'h000000, 1);
    check("after_ignore", 32'(rd[0]), 32'h11);

    csb_low();
    send_cmd_addr(8'h03, 24'h000004, 10, 1'b0);
    csb_high();
    do_read(24'h000004, 1);
    check("after_abort", 32'(rd[0]), 32'h55);

    rd.delete();
    csb_low();
    send_cmd_addr(8'h03, 24'h000000, 24, 1'b1);
    read_bytes(24'h000000, 1);
    spi_bit(1'b0, 1'b0, 24'h0, m);
    spi_bit(1'b0, 1'b0, 24'h0, m);
    repeat (4) @(posedge ap_clk);
    @(negedge ap_clk);
    check("pre_rst_io1", 32'(io1), 32'h1);
    ap_rst = 1'b1;
    #1;
    check("midrst_io1", 32'(io1), 32'h0);
    check("midrst_en", 32'(romcode_EN_A), 32'h0);
    check("midrst_addr", romcode_Addr_A, 32'h0);
    data_phase = 1'b0;
    exp_fetch.delete();
    repeat (3) @(posedge ap_clk);
    #1 ap_rst = 1'b0;
    e0 = en_count;
    send_cmd_addr(8'h03, 24'h000000, 24, 1'b0);
    for (int i = 0; i < 16; i++) spi_bit(1'b0, 1'b0, 24'h0, m);
    csb_high();
    check("held_csb_no_en", 32'(en_count - e0), 32'h0);
    do_read(24'h000000, 1);
    check("after_rst", 32'(rd[0]), 32'h11);

    for (int t = 0; t < 6; t++) begin
      logic [23:0] a;
      a = (t == 0) ? 24'hFFFFFE : 24'($urandom);
      do_read(a, $urandom_range(1, 5));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
